// File: rtl/arb_pkg.sv
// Shared types and helpers for the memory-port round-robin arbiter.
// Used by rr_picker and mem_port_arbiter (see ARB_PERF_CNT_EN in the top).
package arb_pkg;

   localparam int NUM_REQ   = 4;
   localparam int SEL_WIDTH = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   // OR-based encoder; input is expected to be one-hot or zero
   function automatic logic [SEL_WIDTH-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] onehot);
      logic [SEL_WIDTH-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (onehot[i]) begin
            idx = idx | SEL_WIDTH'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request after ptr, wrapping 3->0.
module rr_picker
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0]   req,
   input  logic [SEL_WIDTH-1:0] ptr,
   output logic [NUM_REQ-1:0]   winner,
   output logic                 any
);

   // Offset NUM_REQ wraps back to ptr itself, so ptr is considered last
   always_comb begin
      logic [SEL_WIDTH-1:0] idx;
      idx    = '0;
      winner = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = ptr + SEL_WIDTH'(i);
         if (req[idx] && (winner == '0)) begin
            winner[idx] = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between 4 requesters, with locked bursts.
// Define ARB_PERF_CNT_EN to add per-requester saturating accept counters on grant_cnt.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_lock,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   resp_valid,
   output logic [NUM_REQ-1:0]   grant,
   output logic [SEL_WIDTH-1:0] sel,
   output logic                 mem_valid,
   input  logic                 mem_ready,
`ifdef ARB_PERF_CNT_EN
   output logic [NUM_REQ*CNT_WIDTH-1:0] grant_cnt,
`endif
   input  logic                 mem_resp_valid
);

   localparam int BURST_W = $clog2(MAX_BURST + 1);

   arb_state_t           state, state_next;
   logic [NUM_REQ-1:0]   grant_next;
   logic [SEL_WIDTH-1:0] sel_next;
   logic [SEL_WIDTH-1:0] rr_ptr, rr_ptr_next;
   logic [BURST_W-1:0]   burst_cnt, burst_cnt_next;
   logic [NUM_REQ-1:0]   pick;
   logic                 pick_any;
   logic                 owner_valid;
   logic                 accept;
   logic                 resp_fire;

   rr_picker u_picker (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .winner (pick),
      .any    (pick_any)
   );

   assign owner_valid = req_valid[sel];
   assign mem_valid   = (state == ISSUE) && owner_valid;
   assign accept      = mem_valid && mem_ready;
   assign resp_fire   = (state == RESP) && mem_resp_valid;
   assign req_ready   = accept    ? grant : '0;
   assign resp_valid  = resp_fire ? grant : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         sel       <= '0;
         rr_ptr    <= SEL_WIDTH'(NUM_REQ - 1);
         burst_cnt <= '0;
      end else begin
         state     <= state_next;
         grant     <= grant_next;
         sel       <= sel_next;
         rr_ptr    <= rr_ptr_next;
         burst_cnt <= burst_cnt_next;
      end
   end

   // Releasing ownership always records the last owner so it drops to lowest priority
   always_comb begin
      state_next     = state;
      grant_next     = grant;
      sel_next       = sel;
      rr_ptr_next    = rr_ptr;
      burst_cnt_next = burst_cnt;
      unique case (state)
         IDLE: begin
            if (pick_any) begin
               grant_next = pick;
               sel_next   = onehot_to_idx(pick);
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (!owner_valid) begin
               state_next     = IDLE;
               rr_ptr_next    = sel;
               grant_next     = '0;
               sel_next       = '0;
               burst_cnt_next = '0;
            end else if (mem_ready) begin
               burst_cnt_next = burst_cnt + BURST_W'(1);
               state_next     = RESP;
            end
         end
         RESP: begin
            if (mem_resp_valid) begin
               if (req_lock[sel] && owner_valid && (burst_cnt < BURST_W'(MAX_BURST))) begin
                  state_next = ISSUE;
               end else begin
                  state_next     = IDLE;
                  rr_ptr_next    = sel;
                  grant_next     = '0;
                  sel_next       = '0;
                  burst_cnt_next = '0;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

`ifdef ARB_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];

   // Counters hold at all-ones and are cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && (cnt_q[i] != '1)) begin
               cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
      end
   end
`endif

endmodule
